// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank and the write-back stage.
// The no-write opcode lives here so every stage agrees on it.
package register_bank_pkg;
  localparam int DATA_W    = 20;
  localparam int ADDR_W    = 4;
  localparam int CNT_W     = 2;
  localparam int NUM_REGS  = 2 ** ADDR_W;
  localparam int WB_ADDR_W = 20;
  localparam int INSTR_W   = 20;

  localparam logic [3:0] OP_STORE  = 4'b1100;
  localparam logic [3:0] OP_LOAD_A = 4'b1101;
  localparam logic [3:0] OP_LOAD_B = 4'b1111;

  // Stores are the only instructions that never reach write-back with a result.
  function automatic logic writesReg(input logic [INSTR_W-1:0] instr);
    return instr[19:16] != OP_STORE;
  endfunction
endpackage

// File: rtl/register_bank_if.sv
// Write-back, operand-read and issue signals between the pipeline and register_bank.
// Issue handshake: decode holds issueValid and the instruction until issueAccepted.
interface register_bank_if;
  import register_bank_pkg::*;

  logic                 writeBackEnable;
  logic [WB_ADDR_W-1:0] writeBackAddress;
  logic [DATA_W-1:0]    writeBackData;
  logic [ADDR_W-1:0]    readAddrA;
  logic [ADDR_W-1:0]    readAddrB;
  logic [DATA_W-1:0]    readDataA;
  logic [DATA_W-1:0]    readDataB;
  logic                 issueValid;
  logic [INSTR_W-1:0]   issueInstruction;
  logic [ADDR_W-1:0]    issueDest;
  logic                 useA;
  logic                 useB;
  logic                 stall;
  logic                 issueAccepted;

  modport master (
    output writeBackEnable, writeBackAddress, writeBackData,
    output readAddrA, readAddrB, issueValid, issueInstruction, issueDest, useA, useB,
    input  readDataA, readDataB, stall, issueAccepted
  );

  modport slave (
    input  writeBackEnable, writeBackAddress, writeBackData,
    input  readAddrA, readAddrB, issueValid, issueInstruction, issueDest, useA, useB,
    output readDataA, readDataB, stall, issueAccepted
  );
endinterface

// File: rtl/register_bank_scoreboard.sv
// Per-register pending-write counters plus RAW hazard / saturation stall logic.
module pending_scoreboard
  import register_bank_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wbEnable,
  input  logic [ADDR_W-1:0] wbIndex,
  input  logic              issueValid,
  input  logic              issueWrites,
  input  logic [ADDR_W-1:0] issueDest,
  input  logic              useA,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic              useB,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic              stall,
  output logic              issueAccepted
);
  logic [CNT_W-1:0] pend [NUM_REGS];
  logic hazA, hazB, sat;
  logic clrA, clrB, clrDest;

  assign clrA    = wbEnable && (wbIndex == readAddrA);
  assign clrB    = wbEnable && (wbIndex == readAddrB);
  assign clrDest = wbEnable && (wbIndex == issueDest);

  // A last outstanding write landing this cycle is served by the bypass mux.
  assign hazA = useA && (pend[readAddrA] != '0) && !((pend[readAddrA] == CNT_W'(1)) && clrA);
  assign hazB = useB && (pend[readAddrB] != '0) && !((pend[readAddrB] == CNT_W'(1)) && clrB);
  assign sat  = issueWrites && (pend[issueDest] == {CNT_W{1'b1}}) && !clrDest;

  assign stall         = reset || (issueValid && (hazA || hazB || sat));
  assign issueAccepted = issueValid && !stall;

  always_ff @(posedge clock) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        pend[r] <= '0;
      end else begin
        logic inc, dec;
        inc = issueAccepted && issueWrites && (issueDest == ADDR_W'(r));
        dec = wbEnable && (wbIndex == ADDR_W'(r)) && (pend[r] != '0);
        if (inc && !dec)
          pend[r] <= pend[r] + CNT_W'(1);
        else if (dec && !inc)
          pend[r] <= pend[r] - CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/register_bank.sv
// Architectural register file: write-back port, two bypassed read ports,
// and the pending-write scoreboard that stalls decode on RAW hazards.
module register_bank
  import register_bank_pkg::*;
(
  input logic      clock,
  input logic      reset,
  register_bank_if.slave bus
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] wbIndex;
  logic              unusedBits;

  assign wbIndex    = bus.writeBackAddress[ADDR_W-1:0];
  assign unusedBits = ^{bus.writeBackAddress[WB_ADDR_W-1:ADDR_W], bus.issueInstruction[15:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (bus.writeBackEnable) begin
      regs[wbIndex] <= bus.writeBackData;
    end
  end

  always_comb begin
    bus.readDataA = '0;
    bus.readDataB = '0;
    if (!reset) begin
      bus.readDataA = (bus.writeBackEnable && wbIndex == bus.readAddrA) ? bus.writeBackData
                                                                        : regs[bus.readAddrA];
      bus.readDataB = (bus.writeBackEnable && wbIndex == bus.readAddrB) ? bus.writeBackData
                                                                        : regs[bus.readAddrB];
    end
  end

  pending_scoreboard u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .wbEnable      (bus.writeBackEnable),
    .wbIndex       (wbIndex),
    .issueValid    (bus.issueValid),
    .issueWrites   (writesReg(bus.issueInstruction)),
    .issueDest     (bus.issueDest),
    .useA          (bus.useA),
    .readAddrA     (bus.readAddrA),
    .useB          (bus.useB),
    .readAddrB     (bus.readAddrB),
    .stall         (bus.stall),
    .issueAccepted (bus.issueAccepted)
  );
endmodule

// File: tb/tb_register_bank.sv
// Directed table-driven bench for register_bank: reads, bypass, hazards,
// saturation, upper-address masking and reset in flight.
module tb_register_bank;
  import register_bank_pkg::*;

  localparam logic [19:0] OP1 = 20'h10000;
  localparam logic [19:0] ST  = 20'hC0000;

  logic clock;
  logic reset;
  register_bank_if bus ();

  register_bank dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wbE;
    logic [19:0] wbA;
    logic [19:0] wbD;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        iv;
    logic [19:0] instr;
    logic [3:0]  dest;
    logic        uA;
    logic        uB;
    logic [19:0] expA;
    logic [19:0] expB;
    logic        expStall;
    logic        expAcc;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];
  int checks;
  int failures;

  function automatic vec_t mk(logic wbE, logic [19:0] wbA, logic [19:0] wbD,
                              logic [3:0] rA, logic [3:0] rB, logic iv,
                              logic [19:0] instr, logic [3:0] dest, logic uA, logic uB,
                              logic [19:0] expA, logic [19:0] expB,
                              logic expStall, logic expAcc);
    vec_t v;
    v.wbE = wbE; v.wbA = wbA; v.wbD = wbD; v.rA = rA; v.rB = rB; v.iv = iv;
    v.instr = instr; v.dest = dest; v.uA = uA; v.uB = uB;
    v.expA = expA; v.expB = expB; v.expStall = expStall; v.expAcc = expAcc;
    return v;
  endfunction

  // Driver
  task automatic drive(input vec_t v);
    bus.writeBackEnable  = v.wbE;
    bus.writeBackAddress = v.wbA;
    bus.writeBackData    = v.wbD;
    bus.readAddrA        = v.rA;
    bus.readAddrB        = v.rB;
    bus.issueValid       = v.iv;
    bus.issueInstruction = v.instr;
    bus.issueDest        = v.dest;
    bus.useA             = v.uA;
    bus.useB             = v.uB;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".readDataA"}, bus.readDataA, v.expA);
    check({tag, ".readDataB"}, bus.readDataB, v.expB);
    check({tag, ".stall"}, 20'(bus.stall), 20'(v.expStall));
    check({tag, ".issueAccepted"}, 20'(bus.issueAccepted), 20'(v.expAcc));
  endtask

  initial begin
    vec_t h;
    checks   = 0;
    failures = 0;

    //              wbE wbA        wbD        rA    rB    iv   instr dest  uA   uB   expA       expB       st   acc
    vecs[0]  = mk(0, 20'h0,     20'h0,     3,    7,    0,   OP1,  0,    0,   0,   20'h0,     20'h0,     0,   0);
    vecs[1]  = mk(1, 20'h00005, 20'hABCDE, 5,    0,    0,   OP1,  0,    0,   0,   20'hABCDE, 20'h0,     0,   0);
    vecs[2]  = mk(0, 20'h0,     20'h0,     5,    0,    0,   OP1,  0,    0,   0,   20'hABCDE, 20'h0,     0,   0);
    vecs[3]  = mk(0, 20'h0,     20'h0,     0,    0,    1,   OP1,  2,    0,   0,   20'h0,     20'h0,     0,   1);
    vecs[4]  = mk(0, 20'h0,     20'h0,     2,    0,    1,   OP1,  3,    1,   0,   20'h0,     20'h0,     1,   0);
    vecs[5]  = mk(0, 20'h0,     20'h0,     2,    0,    1,   OP1,  3,    1,   0,   20'h0,     20'h0,     1,   0);
    vecs[6]  = mk(1, 20'h00002, 20'h12345, 2,    0,    1,   OP1,  3,    1,   0,   20'h12345, 20'h0,     0,   1);
    vecs[7]  = mk(0, 20'h0,     20'h0,     2,    2,    0,   OP1,  0,    1,   1,   20'h12345, 20'h12345, 0,   0);
    vecs[8]  = mk(0, 20'h0,     20'h0,     0,    0,    1,   ST,   4,    0,   0,   20'h0,     20'h0,     0,   1);
    vecs[9]  = mk(0, 20'h0,     20'h0,     4,    0,    1,   OP1,  5,    1,   0,   20'h0,     20'h0,     0,   1);
    vecs[10] = mk(0, 20'h0,     20'h0,     0,    0,    1,   OP1,  6,    0,   0,   20'h0,     20'h0,     0,   1);
    vecs[11] = mk(0, 20'h0,     20'h0,     0,    0,    1,   OP1,  6,    0,   0,   20'h0,     20'h0,     0,   1);
    vecs[12] = mk(0, 20'h0,     20'h0,     0,    0,    1,   OP1,  6,    0,   0,   20'h0,     20'h0,     0,   1);
    vecs[13] = mk(0, 20'h0,     20'h0,     0,    0,    1,   OP1,  6,    0,   0,   20'h0,     20'h0,     1,   0);
    vecs[14] = mk(1, 20'h00006, 20'h00066, 6,    0,    1,   OP1,  6,    0,   0,   20'h00066, 20'h0,     0,   1);
    vecs[15] = mk(0, 20'h0,     20'h0,     6,    0,    1,   OP1,  6,    0,   0,   20'h00066, 20'h0,     1,   0);
    vecs[16] = mk(1, 20'h00006, 20'h00077, 6,    0,    1,   OP1,  7,    1,   0,   20'h00077, 20'h0,     1,   0);
    vecs[17] = mk(1, 20'h00006, 20'h00088, 6,    0,    0,   OP1,  0,    0,   0,   20'h00088, 20'h0,     0,   0);
    vecs[18] = mk(1, 20'h00006, 20'h00099, 6,    0,    1,   OP1,  8,    1,   0,   20'h00099, 20'h0,     0,   1);
    vecs[19] = mk(1, 20'hF0009, 20'h5A5A5, 9,    0,    0,   OP1,  0,    0,   0,   20'h5A5A5, 20'h0,     0,   0);
    vecs[20] = mk(0, 20'h0,     20'h0,     9,    1,    0,   OP1,  0,    0,   0,   20'h5A5A5, 20'h0,     0,   0);
    vecs[21] = mk(1, 20'h00001, 20'h11111, 0,    1,    0,   OP1,  0,    0,   0,   20'h0,     20'h11111, 0,   0);
    vecs[22] = mk(0, 20'h0,     20'h0,     0,    1,    1,   OP1,  10,   0,   1,   20'h0,     20'h11111, 0,   1);
    vecs[23] = mk(0, 20'h0,     20'h0,     5,    1,    1,   OP1,  11,   1,   1,   20'hABCDE, 20'h11111, 1,   0);
    vecs[24] = mk(0, 20'h0,     20'h0,     5,    1,    0,   OP1,  11,   1,   1,   20'hABCDE, 20'h11111, 0,   0);
    vecs[25] = mk(0, 20'h0,     20'h0,     0,    8,    1,   OP1,  11,   0,   1,   20'h0,     20'h0,     1,   0);
    vecs[26] = mk(0, 20'h0,     20'h0,     10,   0,    1,   OP1,  10,   1,   0,   20'h0,     20'h0,     1,   0);

    // Reset held with an issue attempt and a write-back to r7 that must be dropped
    reset = 1'b1;
    drive(mk(1, 20'h00007, 20'hFFFFF, 3, 7, 1, OP1, 1, 1, 1, 0, 0, 1, 0));
    repeat (3) @(posedge clock);
    #4;
    h = mk(1, 20'h00007, 20'hFFFFF, 3, 7, 1, OP1, 1, 1, 1, 20'h0, 20'h0, 1, 0);
    check_vec("in_reset", h);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #4;
      check_vec($sformatf("vec%0d", i), vecs[i]);
      @(posedge clock);
      #1;
    end

    // Reset in flight clears pend and drops the coincident write to r9
    reset = 1'b1;
    drive(mk(1, 20'h00009, 20'h12121, 9, 5, 1, OP1, 12, 0, 0, 0, 0, 1, 0));
    #4;
    h = mk(1, 20'h00009, 20'h12121, 9, 5, 1, OP1, 12, 0, 0, 20'h0, 20'h0, 1, 0);
    check_vec("reset_mid", h);
    @(posedge clock);
    #1;
    reset = 1'b0;
    h = mk(0, 20'h0, 20'h0, 9, 5, 1, OP1, 12, 1, 1, 20'h0, 20'h0, 0, 1);
    drive(h);
    #4;
    check_vec("post_reset", h);
    @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Architectural register file at the receiving end of the write-back interface.
- Consumes the write-back stage's enable/address/data triple and serves two operand read ports to decode.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards until the producing instruction reaches write-back.
- Sits between decode (read/issue side) and write-back (write side); the 20-bit data path matches the rest of the pipeline.

Parameters:
- DATA_W, 20, register and data width
- ADDR_W, 4, register index width (2**ADDR_W registers)
- CNT_W, 2, pending-write counter width per register (max 2**CNT_W-1 writes in flight)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- writeBackEnable  input  1  write strobe from write-back stage
- writeBackAddress  input  20  destination from write-back; only bits [ADDR_W-1:0] used, upper bits ignored
- writeBackData  input  DATA_W  data to write
- readAddrA  input  ADDR_W  source A index
- readAddrB  input  ADDR_W  source B index
- readDataA  output  DATA_W  source A value
- readDataB  output  DATA_W  source B value
- issueValid  input  1  decode attempts to issue an instruction this cycle
- issueInstruction  input  20  issuing instruction; opcode = [19:16]
- issueDest  input  ADDR_W  destination of issuing instruction
- useA  input  1  issuing instruction reads source A
- useB  input  1  issuing instruction reads source B
- stall  output  1  issue refused this cycle; decode holds the instruction
- issueAccepted  output  1  issueValid & ~stall

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops; pending counter pend[r] of CNT_W bits per register.
- Reset (synchronous): all registers = 0; all pend = 0. While reset is high, stall = 1 and issueAccepted = 0. Reads during reset return 0. An in-flight write-back coincident with reset is discarded.
- Write: on a rising edge with writeBackEnable=1, reg[writeBackAddress[ADDR_W-1:0]] <= writeBackData. Single-cycle latency.
- Read: combinational. Write-through bypass: if writeBackEnable and the low ADDR_W bits of writeBackAddress == readAddrX, readDataX = writeBackData; else readDataX = reg[readAddrX].
- Writes-register decode: issueWrites = (issueInstruction[19:16] != 4'b1100). Opcode 1100 produces no write-back, so it never sets a pending entry.
- Pending-clear qualifier: wbClr[r] = writeBackEnable & (wb low bits == r).
- Hazard: hazX = useX & (pend[readAddrX] != 0) & ~(pend[readAddrX]==1 & wbClr[readAddrX]). A final write landing this cycle is covered by the bypass and does not stall.
- Saturation: sat = issueWrites & (pend[issueDest] == all-ones) & ~wbClr[issueDest].
- stall = issueValid & (hazA | hazB | sat); stall = 0 when issueValid = 0.
- Counter update per register r, each edge: inc = issueAccepted & issueWrites & (issueDest==r); dec = wbClr[r] & (pend[r]!=0).
  - inc&~dec: +1
  - dec&~inc: -1
  - both: unchanged
- A write-back to a register with pend=0 (e.g. a stray write after reset) updates the data but leaves pend at 0; no underflow.
- Both ports may read the same register; an instruction may use the same register for source and destination. The hazard check uses the pre-issue pend value.

Decomposition:
- Shared package: DATA_W, ADDR_W, opcode constants (OP_STORE=4'b1100, OP_LOAD_A=4'b1101, OP_LOAD_B=4'b1111). The write-back stage and register_bank both use these constants, so the no-write opcode is defined once.
- One sub-module: pending_scoreboard (pend counters, hazard, sat, stall). The storage array and bypass mux stay in the top.

Test Plan:
- Reset, then read r3 on A and r7 on B -> readDataA = readDataB = 0; stall = 0 with issueValid = 0. Holding reset with issueValid = 1 -> stall = 1.
- writeBackEnable = 1, address = 20'h00005, data = 20'hABCDE, readAddrA = 5 in the same cycle -> readDataA = 20'hABCDE (bypass). Next cycle, enable low -> still 20'hABCDE from storage.
- Issue opcode 4'b0001, dest r2 -> accepted, pend[2] = 1. Next issue with useA, readAddrA = 2 -> stall = 1 until write-back to r2. In the write-back cycle, stall = 0 and readDataA = write-back data.
- Issue opcode 4'b1100, dest r4 -> pend[4] stays 0. Subsequent reader of r4 is not stalled.
- Three accepted issues to r6 without write-back -> pend[6] = 3. A fourth issue to r6 -> stall (sat). Issue to r6 in the same cycle as a write-back to r6 -> accepted, pend stays 3.
- Write-back to address 20'hF0009 -> r9 written (upper bits ignored). Write-back to r1 with pend[1] = 0 -> data written, pend[1] stays 0.
